// File: rtl/ysyx_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the all-zero instruction used for faulted fetches, and the width helper
// for the optional response timeout counter (YSYX_IFU_TIMEOUT_EN).
package ysyx_ifu_pkg;

    typedef enum logic [2:0] {
        IFU_IDLE  = 3'd0,
        IFU_REQ   = 3'd1,
        IFU_WAIT  = 3'd2,
        IFU_HOLD  = 3'd3,
        IFU_DRAIN = 3'd4
    } ifu_state_t;

    localparam logic [31:0] INST_ZERO = 32'h0000_0000;

    // Counter must be able to hold the value TIMEOUT_CYCLES itself.
    function automatic int timeout_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/ysyx_inst_fetch.sv
// Instruction fetch stage: takes one PC, issues one 32-bit read, and hands
// the word (tagged with its PC) to decode over valid/ready. A flush drops the
// fetch in flight; if memory already owes a response, the FSM drains it first.
// Optional feature: define YSYX_IFU_TIMEOUT_EN to bound the wait for a
// response to TIMEOUT_CYCLES cycles (in WAIT and DRAIN).
module ysyx_inst_fetch
    import ysyx_ifu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_valid,
    input  logic [XLEN-1:0] pc,
    output logic            pc_ready,
    input  logic            flush,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic            fetch_err
);

    // A zero-cycle timeout is meaningless; this empty block only exists when
    // the parameter is out of range so it shows up in the elaborated hierarchy.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_invalid
    end

    ifu_state_t      state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] inst_reg, inst_next;
    logic [XLEN-1:0] inst_pc_reg, inst_pc_next;
    logic            err_reg, err_next;

`ifdef YSYX_IFU_TIMEOUT_EN
    localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

    // Outputs come straight from state/registers; only pc_ready also looks
    // at flush and reset so a redirect never races a new PC in.
    assign pc_ready      = rst & (state_reg == IFU_IDLE) & ~flush;
    assign mem_req_valid = (state_reg == IFU_REQ);
    assign mem_req_addr  = pc_reg;
    assign inst_valid    = (state_reg == IFU_HOLD);
    assign inst          = inst_reg;
    assign inst_pc       = inst_pc_reg;
    assign fetch_err     = err_reg;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IFU_IDLE;
            pc_reg      <= '0;
            inst_reg    <= '0;
            inst_pc_reg <= '0;
            err_reg     <= 1'b0;
`ifdef YSYX_IFU_TIMEOUT_EN
            cnt_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            inst_reg    <= inst_next;
            inst_pc_reg <= inst_pc_next;
            err_reg     <= err_next;
`ifdef YSYX_IFU_TIMEOUT_EN
            cnt_reg     <= cnt_next;
`endif
        end
    end

    // Next-state and capture logic; flush takes priority in every state
    // except DRAIN, which must always swallow the owed response.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        inst_next    = inst_reg;
        inst_pc_next = inst_pc_reg;
        err_next     = err_reg;
`ifdef YSYX_IFU_TIMEOUT_EN
        cnt_next     = cnt_reg;
`endif
        case (state_reg)
            IFU_IDLE: begin
                if (pc_valid && pc_ready) begin
                    pc_next = pc;
                    if (pc[1:0] != 2'b00) begin
                        // Misaligned: report straight to decode, no bus access.
                        state_next   = IFU_HOLD;
                        inst_next    = XLEN'(INST_ZERO);
                        inst_pc_next = pc;
                        err_next     = 1'b1;
                    end else begin
                        state_next = IFU_REQ;
                    end
                end
            end
            IFU_REQ: begin
                if (flush) begin
                    // Once memory has taken the request, it still owes a response.
                    state_next = mem_req_ready ? IFU_DRAIN : IFU_IDLE;
`ifdef YSYX_IFU_TIMEOUT_EN
                    cnt_next   = '0;
`endif
                end else if (mem_req_ready) begin
                    state_next = IFU_WAIT;
`ifdef YSYX_IFU_TIMEOUT_EN
                    cnt_next   = '0;
`endif
                end
            end
            IFU_WAIT: begin
                if (flush) begin
                    state_next = mem_rsp_valid ? IFU_IDLE : IFU_DRAIN;
`ifdef YSYX_IFU_TIMEOUT_EN
                    cnt_next   = '0;
`endif
                end else if (mem_rsp_valid) begin
                    state_next   = IFU_HOLD;
                    inst_next    = mem_rsp_data;
                    inst_pc_next = pc_reg;
                    err_next     = mem_rsp_err;
                end
`ifdef YSYX_IFU_TIMEOUT_EN
                else if (cnt_reg == CNT_LAST) begin
                    state_next   = IFU_HOLD;
                    inst_next    = XLEN'(INST_ZERO);
                    inst_pc_next = pc_reg;
                    err_next     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            IFU_HOLD: begin
                if (flush || inst_ready) begin
                    state_next = IFU_IDLE;
                end
            end
            IFU_DRAIN: begin
                if (mem_rsp_valid) begin
                    state_next = IFU_IDLE;
                end
`ifdef YSYX_IFU_TIMEOUT_EN
                else if (cnt_reg == CNT_LAST) begin
                    state_next = IFU_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            default: begin
                state_next = IFU_IDLE;
            end
        endcase
    end

endmodule
